is_array_controller: RTL
========================

Name: is_array_controller

Overview:
- Sequencer for a ROWS x COLS input-stationary systolic array built from processing_element_is cells.
- Runs one tile operation per start: clear, stationary-operand scan-in, streamed compute, result drain.
- Drives the array-wide control broadcasts: reg_clear, cscan_en, cell_sc_en seed, pipeline_en, c_switch.
- Sits between the tile scheduler (start/done handshake) and the array; honours downstream backpressure.

Parameters:
- ROWS, 4, array rows; stationary load length in cycles.
- COLS, 4, array columns; drain length in cycles.
- K_W, 16, width of the streamed-vector count k_len.
- STAGE, 0, extra PE pipeline latency in cycles, added to the compute window.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile operation; sampled only in IDLE.
- k_len  in  K_W  number of streamed activation vectors; latched when start is accepted.
- stall  in  1  downstream backpressure; freezes COMPUTE and DRAIN.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of operation.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- reg_clear  out  1  array register clear.
- cscan_en  out  1  stationary-operand scan enable.
- cell_sc_en  out  1  cell-enable seed into the first PE of the chain.
- pipeline_en  out  1  array pipeline advance.
- c_switch  out  1  selects local MAC register onto MAC_OUT for drain.
- out_valid  out  1  drained column result valid this cycle.

Behaviour:
- Reset (async, rst=1): state=IDLE, all counters 0, every output 0. Reset mid-operation aborts immediately; no done pulse.
- FSM states: IDLE, CLEAR, LOAD, COMPUTE, DRAIN, FIN.
- IDLE: start=1 with k_len!=0 -> latch k_len into len_q, go to CLEAR. start=1 with k_len==0 -> cfg_err=1 for the next cycle, remain IDLE. busy=0.
- CLEAR: exactly 1 cycle; reg_clear=1. Next state LOAD.
- LOAD: ROWS cycles; cscan_en=1 every cycle; cell_sc_en=1 on the first LOAD cycle only. stall is ignored. Next state COMPUTE.
- COMPUTE: T_C = len_q + ROWS + COLS - 2 + STAGE advancing cycles. pipeline_en = ~stall. The counter advances only when stall=0. Next state DRAIN after the last advancing cycle.
- DRAIN: COLS advancing cycles; c_switch=1 for the whole state, including stalled cycles. out_valid = pipeline_en = ~stall. The counter advances only when stall=0.
- FIN: 1 cycle; done=1, busy=1. Next state IDLE.
- Outputs are registered (decoded from the next-state value), so each output is aligned with its state cycle.
- start while busy: ignored and not queued.
- Counter width: max(K_W, clog2(ROWS+COLS+STAGE))+1. Computing T_C must not overflow when len_q is at its maximum.
- stall asserted in CLEAR, LOAD or FIN: no effect.

Test Plan:
- Nominal (ROWS=4, COLS=4, STAGE=0), start pulse in cycle 0 with k_len=8, stall=0 -> reg_clear in cycle 1; cscan_en in cycles 2-5 with cell_sc_en only in cycle 2; pipeline_en in cycles 6-19 (14 cycles); c_switch/out_valid in cycles 20-23; done in cycle 24; busy in cycles 1-24.
- Stall in COMPUTE, same setup, stall=1 in cycles 10-12 -> pipeline_en=0 in cycles 10-12; compute ends in cycle 22; done in cycle 27.
- Stall in DRAIN, stall=1 in cycle 21 -> c_switch stays 1; out_valid=0 in cycle 21; 4 out_valid cycles in total; done in cycle 25.
- Zero length, start with k_len=0 -> cfg_err pulse in cycle 1; busy stays 0; no other output toggles.
- Start while busy, second start in cycle 10 with k_len=3 -> ignored; done still in cycle 24; next start is accepted from IDLE.
- Reset mid-run, rst=1 in cycle 12 (COMPUTE) -> all outputs 0 in the same cycle (async); no done pulse; a fresh start after release runs the nominal sequence.
- Maximum length, k_len=2^K_W-1 -> compute window is exactly len+6 cycles with no counter wrap (check with a reduced K_W=4 build: 21 cycles).

Source files
------------

// File: rtl/is_array_controller_if.sv
//------------------------------------------------------------------------------
// Module  : is_array_controller_if
// Brief   : Scheduler/array-facing signal bundle of the IS array sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface is_array_controller_if #(
    parameter int K_W = 16
);
    logic           start;
    logic [K_W-1:0] k_len;
    logic           stall;
    logic           busy;
    logic           done;
    logic           cfg_err;
    logic           reg_clear;
    logic           cscan_en;
    logic           cell_sc_en;
    logic           pipeline_en;
    logic           c_switch;
    logic           out_valid;

    modport master (
        output start, k_len, stall,
        input  busy, done, cfg_err, reg_clear, cscan_en, cell_sc_en,
               pipeline_en, c_switch, out_valid
    );

    modport slave (
        input  start, k_len, stall,
        output busy, done, cfg_err, reg_clear, cscan_en, cell_sc_en,
               pipeline_en, c_switch, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/is_array_controller.sv
//------------------------------------------------------------------------------
// Module  : is_array_controller
// Brief   : Tile sequencer for an input-stationary systolic array:
//           clear, stationary scan-in, streamed compute, result drain.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module is_array_controller #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int K_W   = 16,
    parameter int STAGE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    is_array_controller_if.slave ctl
);
    localparam int SPAN_W = $clog2(ROWS + COLS + STAGE);
    // One guard bit above the widest operand keeps len + fill from wrapping.
    localparam int CW     = ((K_W > SPAN_W) ? K_W : SPAN_W) + 1;

    localparam logic [CW-1:0] c_load_last  = CW'(ROWS - 1);
    localparam logic [CW-1:0] c_drain_last = CW'(COLS - 1);
    localparam logic [CW-1:0] c_fill       = CW'(ROWS + COLS - 2 + STAGE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t         r_state;
    logic [K_W-1:0] r_len;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_cfg_err;
    logic           r_reg_clear;
    logic           r_cscan_en;
    logic           r_cell_sc_en;
    logic           r_compute;
    logic           r_drain;

    logic [CW-1:0]  w_tc;
    logic [CW-1:0]  w_cnt_inc;

    assign w_tc      = {{(CW-K_W){1'b0}}, r_len} + c_fill;
    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_reg_clear  <= 1'b0;
            r_cscan_en   <= 1'b0;
            r_cell_sc_en <= 1'b0;
            r_compute    <= 1'b0;
            r_drain      <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_reg_clear  <= 1'b0;
            r_cscan_en   <= 1'b0;
            r_cell_sc_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ctl.start) begin
                        if (ctl.k_len != '0) begin
                            r_len       <= ctl.k_len;
                            r_state     <= S_CLEAR;
                            r_busy      <= 1'b1;
                            r_reg_clear <= 1'b1;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state      <= S_LOAD;
                    r_cnt        <= '0;
                    r_cscan_en   <= 1'b1;
                    r_cell_sc_en <= 1'b1;
                end
                S_LOAD: begin
                    if (r_cnt == c_load_last) begin
                        r_state   <= S_COMPUTE;
                        r_cnt     <= '0;
                        r_compute <= 1'b1;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_cscan_en <= 1'b1;
                    end
                end
                S_COMPUTE: begin
                    if (!ctl.stall) begin
                        if (w_cnt_inc == w_tc) begin
                            r_state   <= S_DRAIN;
                            r_cnt     <= '0;
                            r_compute <= 1'b0;
                            r_drain   <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!ctl.stall) begin
                        if (r_cnt == c_drain_last) begin
                            r_state <= S_FIN;
                            r_cnt   <= '0;
                            r_drain <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_busy    <= 1'b0;
                    r_compute <= 1'b0;
                    r_drain   <= 1'b0;
                end
            endcase
        end
    end

    // Stall gates the advance in the same cycle the array sees it.
    assign ctl.pipeline_en = (r_compute | r_drain) & ~ctl.stall;
    assign ctl.out_valid   = r_drain & ~ctl.stall;
    assign ctl.c_switch    = r_drain;
    assign ctl.busy        = r_busy;
    assign ctl.done        = r_done;
    assign ctl.cfg_err     = r_cfg_err;
    assign ctl.reg_clear   = r_reg_clear;
    assign ctl.cscan_en    = r_cscan_en;
    assign ctl.cell_sc_en  = r_cell_sc_en;

endmodule

`default_nettype wire
